// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU and datapath:
// ALU function codes, opcodes, R-type funct codes and controller states.
package multicycle_ctrl_pkg;

  localparam int ALU_CODE_W = 3;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_func_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_IEX    = 4'd8,
    S_IWB    = 4'd9,
    S_BEQ    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. Signal prefixes are from the
// controller's point of view; master = controller, slave = datapath side.
interface multicycle_ctrl_if #(
  parameter int FUNC_SIZE = 11,
  parameter int OP_SIZE   = 6
);
  logic [OP_SIZE-1:0]   i_opcode;
  logic [OP_SIZE-1:0]   i_funct;
  logic                 i_zero;
  logic                 i_mem_ready;
  logic [FUNC_SIZE-1:0] o_alu_func;
  logic                 o_alu_src_a;
  logic [1:0]           o_alu_src_b;
  logic [1:0]           o_pc_src;
  logic                 o_pc_write;
  logic                 o_iord;
  logic                 o_mem_read;
  logic                 o_mem_write;
  logic                 o_ir_write;
  logic                 o_reg_dst;
  logic                 o_mem_to_reg;
  logic                 o_reg_write;
  logic                 o_illegal;
  logic [3:0]           o_state;

  modport master (
    input  i_opcode, i_funct, i_zero, i_mem_ready,
    output o_alu_func, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_write, o_iord,
           o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_illegal, o_state
  );

  modport slave (
    output i_opcode, i_funct, i_zero, i_mem_ready,
    input  o_alu_func, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_write, o_iord,
           o_mem_read, o_mem_write, o_ir_write, o_reg_dst, o_mem_to_reg,
           o_reg_write, o_illegal, o_state
  );
endinterface

// File: rtl/multicycle_ctrl_alu_func_decoder.sv
// R-type funct field to ALU function code; o_valid low for unsupported funct.
module multicycle_ctrl_alu_func_decoder
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_SIZE = 6
) (
  input  logic [OP_SIZE-1:0] i_funct,
  output alu_func_e          o_func,
  output logic               o_valid
);

  always_comb begin
    o_func  = ALU_ADD;
    o_valid = 1'b1;
    case (i_funct)
      FN_ADD:  o_func = ALU_ADD;
      FN_SUB:  o_func = ALU_SUB;
      FN_AND:  o_func = ALU_AND;
      FN_OR:   o_func = ALU_OR;
      FN_XOR:  o_func = ALU_XOR;
      FN_SLT:  o_func = ALU_SLT;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives ALU function, datapath muxes and write strobes.
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4; waits for memory ready
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | A + sign-ext imm -> effective address
// MEMRD  | load read at ALUOut; waits for memory ready
// MEMWB  | MDR -> rt
// MEMWR  | store write at ALUOut; waits for memory ready
// REX    | R-type ALU op selected by funct
// RWB    | ALUOut -> rd
// IEX    | immediate ALU op (addi/andi/ori)
// IWB    | ALUOut -> rt
// BEQ    | A - B, PC <= ALUOut when zero
// JUMP   | PC <= jump target
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int FUNC_SIZE = 11,
  parameter int OP_SIZE   = 6
) (
  input logic                i_clk,
  input logic                i_rst,
  multicycle_ctrl_if.master  bus
);

  state_e    r_state;
  logic      r_illegal;
  alu_func_e w_rfunc;
  logic      w_rvalid;

  alu_func_e w_func;
  logic      w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_pc_src;
  logic      w_pc_write;
  logic      w_iord;
  logic      w_mem_read;
  logic      w_mem_write;
  logic      w_ir_write;
  logic      w_reg_dst;
  logic      w_mem_to_reg;
  logic      w_reg_write;

  multicycle_ctrl_alu_func_decoder #(.OP_SIZE(OP_SIZE)) u_func_dec (
    .i_funct (bus.i_funct),
    .o_func  (w_rfunc),
    .o_valid (w_rvalid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (bus.i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.i_opcode)
            OP_LW, OP_SW:               r_state <= S_MEMADR;
            OP_RTYPE:                   r_state <= S_REX;
            OP_ADDI, OP_ANDI, OP_ORI:   r_state <= S_IEX;
            OP_BEQ:                     r_state <= S_BEQ;
            OP_J:                       r_state <= S_JUMP;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR: r_state <= (bus.i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (bus.i_mem_ready) r_state <= S_MEMWB;
        S_MEMWR:  if (bus.i_mem_ready) r_state <= S_FETCH;
        S_REX: begin
          if (w_rvalid) begin
            r_state <= S_RWB;
          end else begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b1;
          end
        end
        S_IEX:    r_state <= S_IWB;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Decoded from the state register; reset forces every control to zero
  // in the same cycle so an aborted access never strobes memory.
  always_comb begin
    w_func       = ALU_ADD;
    w_src_a      = 1'b0;
    w_src_b      = 2'd0;
    w_pc_src     = 2'd0;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          w_mem_read = 1'b1;
          w_src_b    = 2'd1;
          w_ir_write = bus.i_mem_ready;
          w_pc_write = bus.i_mem_ready;
        end
        S_DECODE: w_src_b = 2'd2;
        S_MEMADR: begin
          w_src_a = 1'b1;
          w_src_b = 2'd2;
        end
        S_MEMRD: begin
          w_iord     = 1'b1;
          w_mem_read = 1'b1;
        end
        S_MEMWB: begin
          w_mem_to_reg = 1'b1;
          w_reg_write  = 1'b1;
        end
        S_MEMWR: begin
          w_iord      = 1'b1;
          w_mem_write = 1'b1;
        end
        S_REX: begin
          w_src_a = 1'b1;
          w_func  = w_rfunc;
        end
        S_RWB: begin
          w_reg_dst   = 1'b1;
          w_reg_write = 1'b1;
          w_func      = w_rfunc;
        end
        S_IEX: begin
          w_src_a = 1'b1;
          case (bus.i_opcode)
            OP_ANDI: begin w_src_b = 2'd3; w_func = ALU_AND; end
            OP_ORI:  begin w_src_b = 2'd3; w_func = ALU_OR;  end
            default: begin w_src_b = 2'd2; w_func = ALU_ADD; end
          endcase
        end
        S_IWB: w_reg_write = 1'b1;
        S_BEQ: begin
          w_src_a    = 1'b1;
          w_func     = ALU_SUB;
          w_pc_src   = 2'd1;
          w_pc_write = bus.i_zero;
        end
        S_JUMP: begin
          w_pc_src   = 2'd2;
          w_pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_alu_func   = {{(FUNC_SIZE-ALU_CODE_W){1'b0}}, w_func};
  assign bus.o_alu_src_a  = w_src_a;
  assign bus.o_alu_src_b  = w_src_b;
  assign bus.o_pc_src     = w_pc_src;
  assign bus.o_pc_write   = w_pc_write;
  assign bus.o_iord       = w_iord;
  assign bus.o_mem_read   = w_mem_read;
  assign bus.o_mem_write  = w_mem_write;
  assign bus.o_ir_write   = w_ir_write;
  assign bus.o_reg_dst    = w_reg_dst;
  assign bus.o_mem_to_reg = w_mem_to_reg;
  assign bus.o_reg_write  = w_reg_write;
  assign bus.o_illegal    = r_illegal;
  assign bus.o_state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: per-instruction cycle model built from the instruction
// rules, checked every cycle, plus directed scenarios with literal pins.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.FUNC_SIZE(11), .OP_SIZE(6)) bus ();
  multicycle_ctrl #(.FUNC_SIZE(11), .OP_SIZE(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [10:0] func;
    logic        src_a;
    logic [1:0]  src_b;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
  } ctl_t;

  typedef enum {P_RST, P_FETCH, P_DEC, P_ADR, P_RD, P_LWB, P_WR,
                P_REX, P_RWB, P_IEX, P_IWB, P_BEQ, P_J} phase_e;

  typedef struct {
    logic       rst;
    logic       ready;
    logic       zero;
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       exp;
    ctl_t       mask;
    bit         ill;
    phase_e     ph;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   model_ill = 1'b0;
  int   n_regw = 0, n_memw = 0, n_pcw = 0;

  function automatic int rfunc(input logic [5:0] fn);
    case (fn)
      6'h20: return 0;
      6'h22: return 1;
      6'h24: return 2;
      6'h25: return 3;
      6'h26: return 4;
      6'h2A: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic void add(input phase_e p, input logic [5:0] op, input logic [5:0] fn,
                              input logic rdy, input logic zr, input bit ill);
    rec_t r;
    ctl_t e, m;
    e = '0;
    m = '0;
    m.pc_write = 1'b1; m.mem_read = 1'b1; m.mem_write = 1'b1;
    m.ir_write = 1'b1; m.reg_write = 1'b1;
    case (p)
      P_RST: m = '1;
      P_FETCH: begin
        m.iord = 1'b1; m.src_a = 1'b1; m.src_b = '1; m.func = '1; m.pc_src = '1;
        e.mem_read = 1'b1; e.src_b = 2'd1; e.ir_write = rdy; e.pc_write = rdy;
      end
      P_DEC: begin
        m.src_a = 1'b1; m.src_b = '1; m.func = '1; e.src_b = 2'd2;
      end
      P_ADR: begin
        m.src_a = 1'b1; m.src_b = '1; m.func = '1; e.src_a = 1'b1; e.src_b = 2'd2;
      end
      P_RD: begin
        m.iord = 1'b1; e.iord = 1'b1; e.mem_read = 1'b1;
      end
      P_LWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      P_WR: begin
        m.iord = 1'b1; e.iord = 1'b1; e.mem_write = 1'b1;
      end
      P_REX: begin
        m.src_a = 1'b1; m.src_b = '1; e.src_a = 1'b1;
        if (rfunc(fn) >= 0) begin m.func = '1; e.func = 11'(rfunc(fn)); end
      end
      P_RWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; m.func = '1;
        e.reg_dst = 1'b1; e.reg_write = 1'b1; e.func = 11'(rfunc(fn));
      end
      P_IEX: begin
        m.src_a = 1'b1; m.src_b = '1; m.func = '1; e.src_a = 1'b1;
        if (op == 6'h08) begin e.src_b = 2'd2; e.func = 11'd0; end
        else if (op == 6'h0C) begin e.src_b = 2'd3; e.func = 11'd2; end
        else begin e.src_b = 2'd3; e.func = 11'd3; end
      end
      P_IWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      P_BEQ: begin
        m.src_a = 1'b1; m.src_b = '1; m.func = '1; m.pc_src = '1;
        e.src_a = 1'b1; e.func = 11'd1; e.pc_src = 2'd1; e.pc_write = zr;
      end
      P_J: begin
        m.pc_src = '1; e.pc_src = 2'd2; e.pc_write = 1'b1;
      end
      default: ;
    endcase
    r.rst = (p == P_RST); r.ready = rdy; r.zero = zr; r.op = op; r.fn = fn;
    r.exp = e; r.mask = m; r.ill = ill; r.ph = p;
    q.push_back(r);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: wf not-ready fetch cycles, wm not-ready memory cycles.
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input logic zr, input int wf, input int wm);
    for (int i = 0; i < wf; i++) add(P_FETCH, 6'($urandom), 6'($urandom), 1'b0, rb(), 0);
    add(P_FETCH, 6'($urandom), 6'($urandom), 1'b1, rb(), 0);
    case (op)
      6'h23: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        add(P_ADR, op, fn, rb(), rb(), 0);
        for (int i = 0; i < wm; i++) add(P_RD, op, fn, 1'b0, rb(), 0);
        add(P_RD, op, fn, 1'b1, rb(), 0);
        add(P_LWB, op, fn, rb(), rb(), 0);
      end
      6'h2B: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        add(P_ADR, op, fn, rb(), rb(), 0);
        for (int i = 0; i < wm; i++) add(P_WR, op, fn, 1'b0, rb(), 0);
        add(P_WR, op, fn, 1'b1, rb(), 0);
      end
      6'h00: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        if (rfunc(fn) >= 0) begin
          add(P_REX, op, fn, rb(), rb(), 0);
          add(P_RWB, op, fn, rb(), rb(), 0);
        end else begin
          add(P_REX, op, fn, rb(), rb(), 1);
        end
      end
      6'h08, 6'h0C, 6'h0D: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        add(P_IEX, op, fn, rb(), rb(), 0);
        add(P_IWB, op, fn, rb(), rb(), 0);
      end
      6'h04: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        add(P_BEQ, op, fn, rb(), zr, 0);
      end
      6'h02: begin
        add(P_DEC, op, fn, rb(), rb(), 0);
        add(P_J, op, fn, rb(), rb(), 0);
      end
      default: add(P_DEC, op, fn, rb(), rb(), 1);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic run_cyc(input rec_t r);
    ctl_t act;
    rst = r.rst;
    bus.i_mem_ready = r.ready;
    bus.i_zero = r.zero;
    bus.i_opcode = r.op;
    bus.i_funct = r.fn;
    @(negedge clk);
    act = {bus.o_alu_func, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_pc_src,
           bus.o_pc_write, bus.o_iord, bus.o_mem_read, bus.o_mem_write,
           bus.o_ir_write, bus.o_reg_dst, bus.o_mem_to_reg, bus.o_reg_write};
    checks++;
    if (((act ^ r.exp) & r.mask) !== '0) begin
      errors++;
      $display("FAIL ctl cyc=%0d phase=%s actual=%h required=%h mask=%h",
               cyc, r.ph.name(), act, r.exp, r.mask);
    end
    checks++;
    if (bus.o_illegal !== model_ill) begin
      errors++;
      $display("FAIL illegal cyc=%0d actual=%b required=%b", cyc, bus.o_illegal, model_ill);
    end
    if (bus.o_reg_write === 1'b1) n_regw++;
    if (bus.o_mem_write === 1'b1) n_memw++;
    if (bus.o_pc_write === 1'b1) n_pcw++;
    @(posedge clk);
    #1;
    if (r.rst) model_ill = 1'b0;
    else if (r.ill) model_ill = 1'b1;
    cyc++;
  endtask

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      run_cyc(r);
    end
  endtask

  task automatic zero_counts();
    n_regw = 0; n_memw = 0; n_pcw = 0;
  endtask

  logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h02, 6'h3F};
  logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h27};

  initial begin
    logic [5:0] op, fn;
    int k;
    rst = 1'b1;
    bus.i_mem_ready = 1'b0; bus.i_zero = 1'b0; bus.i_opcode = '0; bus.i_funct = '0;
    repeat (2) @(posedge clk);
    #1;
    model_ill = 1'b0;

    add(P_RST, 6'h00, 6'h00, 1'b1, 1'b1, 0);
    run_q();
    chk("reset_illegal", int'(bus.o_illegal), 0);

    // R-type add
    zero_counts();
    build(6'h00, 6'h20, 1'b0, 0, 0);
    chk("radd_len", q.size(), 4);
    run_q();
    chk("radd_regw", n_regw, 1);

    // lw with two not-ready cycles in MEMRD
    zero_counts();
    build(6'h23, 6'h00, 1'b0, 0, 2);
    chk("lw_len", q.size(), 7);
    run_q();
    chk("lw_regw", n_regw, 1);
    chk("lw_memw", n_memw, 0);

    // beq taken / not taken
    zero_counts();
    build(6'h04, 6'h00, 1'b1, 0, 0);
    chk("beq_len", q.size(), 3);
    run_q();
    chk("beq_taken_pcw", n_pcw, 2);
    zero_counts();
    build(6'h04, 6'h00, 1'b0, 0, 0);
    run_q();
    chk("beq_not_taken_pcw", n_pcw, 1);

    // ori, sw, j lengths
    build(6'h0D, 6'h00, 1'b0, 0, 0);
    chk("ori_len", q.size(), 4);
    run_q();
    build(6'h2B, 6'h00, 1'b0, 0, 0);
    chk("sw_len", q.size(), 4);
    run_q();
    build(6'h02, 6'h00, 1'b0, 1, 0);
    chk("j_len_fetchwait", q.size(), 4);
    run_q();

    // illegal opcode
    zero_counts();
    build(6'h3F, 6'h00, 1'b0, 0, 0);
    chk("illop_len", q.size(), 2);
    run_q();
    chk("illop_flag", int'(bus.o_illegal), 1);
    chk("illop_writes", n_regw + n_memw, 0);

    // reset clears, then illegal funct through REX
    add(P_RST, 6'h00, 6'h00, 1'b1, 1'b1, 0);
    run_q();
    chk("ill_cleared", int'(bus.o_illegal), 0);
    zero_counts();
    build(6'h00, 6'h27, 1'b0, 0, 0);
    chk("illfn_len", q.size(), 3);
    run_q();
    chk("illfn_flag", int'(bus.o_illegal), 1);
    chk("illfn_writes", n_regw + n_memw, 0);

    // reset while MEMWR is waiting on memory
    zero_counts();
    build(6'h2B, 6'h00, 1'b0, 0, 2);
    while (q.size() > 4) void'(q.pop_back());
    add(P_RST, 6'h2B, 6'h00, 1'b1, 1'b0, 0);
    run_q();
    chk("rst_memwr_memw", n_memw, 1);
    chk("rst_memwr_illegal", int'(bus.o_illegal), 0);
    build(6'h08, 6'h00, 1'b0, 0, 0);
    run_q();

    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 6)];
      build(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, q.size() - 1);
        while (q.size() > k) void'(q.pop_back());
        add(P_RST, op, fn, rb(), rb(), 0);
      end
      run_q();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
